// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared address widths, state encoding and address helper for regfile_dump.
package regfile_dump_pkg;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction
endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: walks an inclusive, wrapping register-file address range and streams each word out.
// Define REGFILE_DUMP_SKIP_ZERO_EN to suppress entries whose value is zero.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        ra_first,
    input  logic [4:0]        ra_last,
    output logic [4:0]        ra,
    input  logic [WIDTH-1:0]  rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [4:0]        out_addr,
    output logic              busy,
    output logic              done
);
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_q, cur_d, last_q, last_d, addr_q, addr_d;
    logic [WIDTH-1:0]   data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: if (start) begin
                cur_d   = ra_first;
                last_d  = ra_last;
                state_d = READ;
            end
            READ: begin
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
                if (rd == '0) begin
                    // Skipped addresses still honour the equality end test.
                    state_d = (cur_q == last_q) ? DONE : READ;
                    cur_d   = (cur_q == last_q) ? cur_q : next_addr(cur_q);
                end else begin
                    data_d  = rd;
                    addr_d  = cur_q;
                    state_d = SEND;
                end
`else
                data_d  = rd;
                addr_d  = cur_q;
                state_d = SEND;
`endif
            end
            SEND: if (out_ready) begin
                state_d = (cur_q == last_q) ? DONE : READ;
                cur_d   = (cur_q == last_q) ? cur_q : next_addr(cur_q);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ra        = cur_q;
    assign out_valid = (state_q == SEND);
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized dumps of a modelled register file checked against an expected-entry queue.
module tb_regfile_dump;
    logic        clk = 0;
    logic        rst, start, out_ready;
    logic [4:0]  ra_first, ra_last, ra, out_addr;
    logic [31:0] rd, out_data;
    logic        out_valid, busy, done;
    logic [31:0] regs [32];
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;
    assign rd = regs[ra];

    regfile_dump #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .ra_first(ra_first), .ra_last(ra_last),
        .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Expected stream: every address from f to l inclusive, modulo 32, optionally minus zero values.
    task automatic dump(input logic [4:0] f, input logic [4:0] l, input int ready_pct,
                        input bit poke, output int cycles);
        int q[$];
        int a, e;
        bit got_done;
        a = f;
        forever begin
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
            if (regs[a] != 0) q.push_back(a);
`else
            q.push_back(a);
`endif
            if (a == l) break;
            a = (a + 1) % 32;
        end
        start = 1; ra_first = f; ra_last = l;
        step;
        start = 0;
        chk("busy_after_start", busy, 1);
        cycles = 1;
        got_done = 0;
        while (!got_done && cycles < 400) begin
            out_ready = ($urandom_range(99) < ready_pct);
            start = poke && (cycles == 3);
            ra_first = 5'($urandom); ra_last = 5'($urandom);
            if (done) begin
                chk("entries_left_at_done", q.size(), 0);
                chk("busy_in_done", busy, 1);
                got_done = 1;
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) chk("extra_entry", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("out_addr", out_addr, e);
                    chk("out_data", out_data, regs[e]);
                end
            end
            if (!got_done) begin
                step;
                cycles++;
            end
        end
        start = 0;
        if (!got_done) chk("done_timeout", 0, 1);
        step;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        int cyc;
        bit seen;
        rst = 1; start = 0; out_ready = 0; ra_first = 0; ra_last = 0;
        for (int i = 0; i < 32; i++) regs[i] = i * 3;
        step; step;
        rst = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ra", ra, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);

        dump(0, 31, 100, 0, cyc);
`ifndef REGFILE_DUMP_SKIP_ZERO_EN
        chk("full_dump_cycles", cyc, 65);
`endif
        dump(30, 1, 100, 0, cyc);
        dump(5, 4, 70, 0, cyc);

        start = 1; ra_first = 7; ra_last = 7;
        step;
        start = 0; out_ready = 0;
        step;
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 21);
            chk("hold_addr", out_addr, 7);
            step;
        end
        out_ready = 1;
        chk("hold_valid_accept", out_valid, 1);
        step;
        out_ready = 0;
        chk("hold_done", done, 1);
        step;
        chk("hold_idle", busy, 0);

        dump(0, 9, 100, 1, cyc);
        dump(20, 3, 50, 1, cyc);

        start = 1; ra_first = 0; ra_last = 9;
        step;
        start = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            seen = out_valid && out_addr == 4;
            out_ready = !seen;
            if (!seen) step;
        end
        chk("reached_entry4", seen, 1);
        rst = 1;
        step;
        rst = 0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ra", ra, 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            seen |= done;
            step;
        end
        chk("rst_mid_no_done", seen, 0);

        regs[2] = 0; regs[3] = 9; regs[4] = 0; regs[5] = 0;
        dump(2, 5, 100, 0, cyc);
        regs[3] = 0;
        dump(2, 5, 100, 0, cyc);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = ($urandom_range(3) == 0) ? 0 : $urandom;
            dump(5'($urandom), 5'($urandom), 60, t[0], cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
